vsm_ctrl: RTL and testbench
===========================

Name: vsm_ctrl

Overview:
Sequencer for one vector-scalar MAC array (SIZE lanes, ACCUMULATIONS products per result). Per job it:
- clears the array accumulators
- streams ACCUMULATIONS weight columns and input scalars from local read-only buffers into the array
- waits out the MAC pipeline
- captures the lane results and offers them downstream on a valid/ready handshake

Sits between the weight/activation buffers and the layer output writer.

Parameters:
- SIZE, 6: lanes in the MAC array.
- WIDTH, 8: bits per lane operand, scalar and result (array is built for 8).
- ACCUMULATIONS, 3: beats (products) per result; must be >= 1.
- MAC_LATENCY, 1: cycles from an operand presented at the array to it being reflected in the array output.
- ADDR_W, 8: weight and activation buffer address width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- base_addr  in  ADDR_W  weight column base; sampled with accepted start.
- busy  out  1  high whenever state != IDLE.
- w_rd_en  out  1  weight buffer read strobe.
- w_addr  out  ADDR_W  weight column address.
- w_data  in  WIDTH*SIZE  weight column; valid the cycle after w_rd_en.
- x_rd_en  out  1  activation buffer read strobe.
- x_addr  out  ADDR_W  activation address.
- x_data  in  WIDTH  scalar; valid the cycle after x_rd_en.
- vsm_clr  out  1  drives the array reset.
- vsm_a  out  WIDTH*SIZE  array vector operand (registered).
- vsm_b  out  WIDTH  array scalar operand (registered).
- vsm_out  in  WIDTH*SIZE  array result.
- res_data  out  WIDTH*SIZE  captured result (registered).
- res_valid  out  1  result available.
- res_ready  in  1  downstream accept.

Behaviour:
- Reset, synchronous:
  - state=IDLE, all counters 0.
  - busy, w_rd_en, x_rd_en, res_valid = 0.
  - w_addr, x_addr, vsm_a, vsm_b, res_data = 0.
  - vsm_clr = reset OR (state==CLEAR), so the array is cleared while reset is high.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: start=1 latches base_addr and moves to CLEAR. start=0 stays in IDLE.
- CLEAR: one cycle, vsm_clr=1, then FEED.
- FEED: ACCUMULATIONS cycles, beat k = 0..ACCUMULATIONS-1.
  - w_rd_en = x_rd_en = 1.
  - w_addr = base + k, modulo 2^ADDR_W (wraps silently).
  - x_addr = k.
  - After the last beat, go to DRAIN.
- Beat pipeline:
  - beat_v is the read strobe delayed 1 cycle.
  - Each cycle: vsm_a <= beat_v ? w_data : 0 and vsm_b <= beat_v ? x_data : 0.
  - Operands outside a job are therefore zero, so the array accumulates nothing.
- DRAIN: 2+MAC_LATENCY cycles. On the last DRAIN cycle, res_data <= vsm_out and go to DONE.
- DONE:
  - res_valid=1; res_data held stable.
  - res_valid & res_ready moves to IDLE on that edge, with res_valid=0 next cycle.
  - start is ignored in every state except IDLE, including DONE.
  - No back-to-back overlap: the next start is accepted one cycle after the handshake at the earliest.
- Latency: start accepted in cycle S gives res_valid first high in cycle S+ACCUMULATIONS+4+MAC_LATENCY (S+8 at defaults).
- Arithmetic (lane width, truncation, saturation) is owned by the MAC array. The controller never modifies lane data.
- Reset mid-operation:
  - Abort at the next edge; all outputs go to reset values.
  - Any in-flight read data is discarded, because beat_v is cleared.
- Simultaneous reset and start: reset wins.

Decomposition:
- Package vsm_ctrl_pkg holds:
  - the state encoding (5-state enum, binary)
  - DRAIN_CYCLES = 2+MAC_LATENCY
  - the counter width function clog2(max(ACCUMULATIONS, DRAIN_CYCLES)+1)
- No sub-module: a single FSM with one shared beat/drain counter and a 1-bit beat_v pipe. The MAC array is instantiated by the parent, not inside this block.

Test Plan:
- Reset: hold reset 3 cycles with random inputs -> every output at its reset value and vsm_clr=1 throughout; busy=0 after release.
- Nominal job (ACCUMULATIONS=3, SIZE=6, ideal MAC model, base_addr=0x10, weight column k all lanes = k+1, x={2,3,4}, start in cycle S):
  - w_addr = 0x10, 0x11, 0x12 and x_addr = 0, 1, 2 in cycles S+2..S+4.
  - vsm_clr=1 in cycle S+1 only.
  - res_valid rises at S+8; every lane of res_data = 0x14.
- Backpressure: hold res_ready=0 for 5 cycles in DONE and pulse start -> res_valid and res_data stable, start ignored. Then res_ready=1 -> IDLE, res_valid=0 next cycle.
- Address wrap: base_addr=0xFE -> w_addr sequence 0xFE, 0xFF, 0x00; result correct.
- Reset mid-FEED (cycle S+3):
  - Next cycle: IDLE, all outputs reset, vsm_a=0.
  - A following job with x={1,1,1} and weights all 1 -> lanes = 0x03, no residue from the aborted job.
- Back-to-back jobs: complete job A (lanes 0x14), start job B one cycle after the handshake with x={0,0,0} -> lanes = 0x00, proving the CLEAR state isolates jobs.

Source files
------------

// File: rtl/vsm_ctrl_pkg.sv
// Shared types and sizing helpers for the vector-scalar MAC sequencer.
package vsm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Cycles spent waiting for the last product to show up at the array output.
  function automatic int unsigned drain_cycles(input int unsigned mac_latency);
    return 32'd2 + mac_latency;
  endfunction

  // Width of the shared beat/drain counter.
  function automatic int unsigned cnt_width(input int unsigned accumulations,
                                            input int unsigned drain);
    int unsigned m;
    m = (accumulations > drain) ? accumulations : drain;
    return $clog2(m + 32'd1);
  endfunction

endpackage

// File: rtl/vsm_ctrl.sv
// Sequencer for one vector-scalar MAC array: clear, feed ACCUMULATIONS beats,
// drain the MAC pipeline, then hold the captured lanes on a valid/ready port.
module vsm_ctrl
  import vsm_ctrl_pkg::*;
#(
  parameter int unsigned SIZE          = 6,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ACCUMULATIONS = 3,
  parameter int unsigned MAC_LATENCY   = 1,
  parameter int unsigned ADDR_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    busy,
  output logic                    w_rd_en,
  output logic [ADDR_W-1:0]       w_addr,
  input  logic [WIDTH*SIZE-1:0]   w_data,
  output logic                    x_rd_en,
  output logic [ADDR_W-1:0]       x_addr,
  input  logic [WIDTH-1:0]        x_data,
  output logic                    vsm_clr,
  output logic [WIDTH*SIZE-1:0]   vsm_a,
  output logic [WIDTH-1:0]        vsm_b,
  input  logic [WIDTH*SIZE-1:0]   vsm_out,
  output logic [WIDTH*SIZE-1:0]   res_data,
  output logic                    res_valid,
  input  logic                    res_ready
);

  localparam int unsigned VEC_W        = WIDTH * SIZE;
  localparam int unsigned DRAIN_CYCLES = drain_cycles(MAC_LATENCY);
  localparam int unsigned CNT_W        = cnt_width(ACCUMULATIONS, DRAIN_CYCLES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                beat_v_q, beat_v_d;
  logic                busy_q, busy_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [ADDR_W-1:0]   x_addr_q, x_addr_d;
  logic [VEC_W-1:0]    vsm_a_q, vsm_a_d;
  logic [WIDTH-1:0]    vsm_b_q, vsm_b_d;
  logic [VEC_W-1:0]    res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;

  // Next state, counter and registered outputs derived from the upcoming state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    res_data_d = res_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (cnt_q == CNT_W'(ACCUMULATIONS - 1)) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          cnt_d      = '0;
          res_data_d = vsm_out;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rd_en_d     = (state_d == ST_FEED);
    w_addr_d    = rd_en_d ? (base_d + ADDR_W'(cnt_d)) : '0;
    x_addr_d    = rd_en_d ? ADDR_W'(cnt_d) : '0;
    // Read data lands one cycle after the strobe; gate it so idle operands are zero.
    beat_v_d    = rd_en_q;
    vsm_a_d     = beat_v_q ? w_data : '0;
    vsm_b_d     = beat_v_q ? x_data : '0;
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      beat_v_q    <= 1'b0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      w_addr_q    <= '0;
      x_addr_q    <= '0;
      vsm_a_q     <= '0;
      vsm_b_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      beat_v_q    <= beat_v_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      w_addr_q    <= w_addr_d;
      x_addr_q    <= x_addr_d;
      vsm_a_q     <= vsm_a_d;
      vsm_b_q     <= vsm_b_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Array clear follows reset directly so accumulators are wiped during reset.
  assign vsm_clr   = reset | (state_q == ST_CLEAR);
  assign busy      = busy_q;
  assign w_rd_en   = rd_en_q;
  assign x_rd_en   = rd_en_q;
  assign w_addr    = w_addr_q;
  assign x_addr    = x_addr_q;
  assign vsm_a     = vsm_a_q;
  assign vsm_b     = vsm_b_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_vsm_ctrl.sv
// Self-checking bench for vsm_ctrl with buffer and ideal MAC array models.
module tb_vsm_ctrl;

  localparam int unsigned SIZE   = 6;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ACC    = 3;
  localparam int unsigned MACL   = 1;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned VEC_W  = WIDTH * SIZE;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic [VEC_W-1:0]  w_data;
  logic              x_rd_en;
  logic [ADDR_W-1:0] x_addr;
  logic [WIDTH-1:0]  x_data;
  logic              vsm_clr;
  logic [VEC_W-1:0]  vsm_a;
  logic [WIDTH-1:0]  vsm_b;
  logic [VEC_W-1:0]  vsm_out;
  logic [VEC_W-1:0]  res_data;
  logic              res_valid;
  logic              res_ready;

  int checks   = 0;
  int failures = 0;

  logic [VEC_W-1:0] wmem [256];
  logic [WIDTH-1:0] xmem [256];
  logic [WIDTH-1:0] acc  [SIZE];

  vsm_ctrl #(
    .SIZE(SIZE), .WIDTH(WIDTH), .ACCUMULATIONS(ACC), .MAC_LATENCY(MACL), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .busy(busy),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .x_rd_en(x_rd_en), .x_addr(x_addr), .x_data(x_data),
    .vsm_clr(vsm_clr), .vsm_a(vsm_a), .vsm_b(vsm_b), .vsm_out(vsm_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Buffers: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    w_data <= w_rd_en ? wmem[w_addr] : VEC_W'({$urandom, $urandom});
    x_data <= x_rd_en ? xmem[x_addr] : WIDTH'($urandom);
  end

  // Ideal MAC array, one cycle from operand to output.
  always @(posedge clk) begin
    for (int l = 0; l < SIZE; l++) begin
      if (vsm_clr) acc[l] <= '0;
      else         acc[l] <= acc[l] + WIDTH'(vsm_a[l*WIDTH +: WIDTH] * vsm_b);
    end
  end

  always_comb begin
    vsm_out = '0;
    for (int l = 0; l < SIZE; l++) vsm_out[l*WIDTH +: WIDTH] = acc[l];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VEC_W-1:0] obs,
                       input logic [VEC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Dot product per lane over the job's beats, truncated to lane width.
  function automatic logic [VEC_W-1:0] expected_result(input logic [ADDR_W-1:0] base);
    logic [VEC_W-1:0] r;
    logic [WIDTH-1:0] sum;
    logic [VEC_W-1:0] col;
    r = '0;
    for (int l = 0; l < SIZE; l++) begin
      sum = '0;
      for (int k = 0; k < ACC; k++) begin
        col = wmem[ADDR_W'(base + ADDR_W'(k))];
        sum = sum + WIDTH'(col[l*WIDTH +: WIDTH] * xmem[k]);
      end
      r[l*WIDTH +: WIDTH] = sum;
    end
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] splat(input logic [WIDTH-1:0] b);
    return {SIZE{b}};
  endfunction

  // Start a job and follow it to the first DONE cycle, checking schedule and result.
  task automatic run_job(input logic [ADDR_W-1:0] base, input logic [VEC_W-1:0] exp);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    check("clr_in_clear", VEC_W'(vsm_clr), VEC_W'(1));
    check("busy_in_clear", VEC_W'(busy), VEC_W'(1));
    check("rd_in_clear", VEC_W'(w_rd_en), VEC_W'(0));
    for (int k = 0; k < ACC; k++) begin
      tick();
      check("w_rd_en_feed", VEC_W'(w_rd_en), VEC_W'(1));
      check("x_rd_en_feed", VEC_W'(x_rd_en), VEC_W'(1));
      check("w_addr_feed", VEC_W'(w_addr), VEC_W'(ADDR_W'(base + ADDR_W'(k))));
      check("x_addr_feed", VEC_W'(x_addr), VEC_W'(k));
      check("clr_feed", VEC_W'(vsm_clr), VEC_W'(0));
    end
    for (int d = 0; d < MACL + 2; d++) begin
      tick();
      check("valid_early", VEC_W'(res_valid), VEC_W'(0));
      check("rd_in_drain", VEC_W'(w_rd_en), VEC_W'(0));
    end
    tick();
    check("valid_latency", VEC_W'(res_valid), VEC_W'(1));
    check("res_data", res_data, exp);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("valid_after_hs", VEC_W'(res_valid), VEC_W'(0));
    check("busy_after_hs", VEC_W'(busy), VEC_W'(0));
  endtask

  initial begin
    logic [VEC_W-1:0] held;
    logic [VEC_W-1:0] exp;
    logic [ADDR_W-1:0] b;

    for (int i = 0; i < 256; i++) begin
      wmem[i] = VEC_W'({$urandom, $urandom});
      xmem[i] = WIDTH'($urandom);
    end
    start = 1'b0; base_addr = '0; res_ready = 1'b0;

    // Reset held for three cycles under random inputs.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start     = 1'($urandom);
      base_addr = ADDR_W'($urandom);
      res_ready = 1'($urandom);
      tick();
      check("rst_clr", VEC_W'(vsm_clr), VEC_W'(1));
      check("rst_busy", VEC_W'(busy), VEC_W'(0));
      check("rst_rd", VEC_W'({w_rd_en, x_rd_en, res_valid}), VEC_W'(0));
      check("rst_addr", VEC_W'({w_addr, x_addr}), VEC_W'(0));
      check("rst_vsm_a", vsm_a, '0);
      check("rst_vsm_b", VEC_W'(vsm_b), VEC_W'(0));
      check("rst_res_data", res_data, '0);
    end
    reset = 1'b0; start = 1'b0; res_ready = 1'b0;
    tick();
    check("post_rst_busy", VEC_W'(busy), VEC_W'(0));
    check("post_rst_clr", VEC_W'(vsm_clr), VEC_W'(0));

    // Nominal job.
    for (int k = 0; k < ACC; k++) wmem[8'h10 + k] = splat(WIDTH'(k + 1));
    xmem[0] = 8'd2; xmem[1] = 8'd3; xmem[2] = 8'd4;
    exp = expected_result(8'h10);
    check("nominal_model", exp, splat(8'h14));
    run_job(8'h10, exp);

    // Backpressure in DONE with start pulses ignored.
    held = res_data;
    for (int i = 0; i < 5; i++) begin
      start     = 1'(i % 2 == 0);
      base_addr = ADDR_W'($urandom);
      tick();
      check("bp_valid", VEC_W'(res_valid), VEC_W'(1));
      check("bp_data", res_data, held);
      check("bp_busy", VEC_W'(busy), VEC_W'(1));
      check("bp_no_read", VEC_W'(w_rd_en), VEC_W'(0));
    end
    start = 1'b0;
    handshake();
    tick();
    check("idle_stays", VEC_W'(busy), VEC_W'(0));

    // Address wrap.
    for (int k = 0; k < ACC; k++) begin
      wmem[ADDR_W'(8'hFE + k)] = VEC_W'({$urandom, $urandom});
      xmem[k] = WIDTH'($urandom);
    end
    run_job(8'hFE, expected_result(8'hFE));
    handshake();

    // Reset in the middle of FEED.
    xmem[0] = 8'hFF; xmem[1] = 8'hFF; xmem[2] = 8'hFF;
    start = 1'b1; base_addr = 8'h40;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", VEC_W'(busy), VEC_W'(0));
    check("abort_rd", VEC_W'({w_rd_en, x_rd_en, res_valid}), VEC_W'(0));
    check("abort_vsm_a", vsm_a, '0);
    check("abort_vsm_b", VEC_W'(vsm_b), VEC_W'(0));
    tick();
    check("abort_vsm_a_after", vsm_a, '0);
    for (int k = 0; k < ACC; k++) begin
      wmem[8'h20 + k] = splat(8'h01);
      xmem[k] = 8'h01;
    end
    run_job(8'h20, splat(8'h03));
    handshake();

    // Back-to-back jobs separated by the minimum gap.
    for (int k = 0; k < ACC; k++) wmem[8'h10 + k] = splat(WIDTH'(k + 1));
    xmem[0] = 8'd2; xmem[1] = 8'd3; xmem[2] = 8'd4;
    run_job(8'h10, splat(8'h14));
    for (int k = 0; k < ACC; k++) xmem[k] = 8'h00;
    handshake();
    run_job(8'h10, splat(8'h00));
    handshake();

    // Random jobs with random response delay.
    for (int j = 0; j < 6; j++) begin
      b = ADDR_W'($urandom);
      for (int k = 0; k < ACC; k++) begin
        wmem[ADDR_W'(b + ADDR_W'(k))] = VEC_W'({$urandom, $urandom});
        xmem[k] = WIDTH'($urandom);
      end
      exp = expected_result(b);
      run_job(b, exp);
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
        tick();
        check("rand_hold_valid", VEC_W'(res_valid), VEC_W'(1));
        check("rand_hold_data", res_data, exp);
      end
      handshake();
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
